// File: rtl/sd_clk_supply_seq.sv
// SD clock supply: write freq select + internal clock enable, poll Internal Clock Stable, then enable SDCLK.
// Latency: 3*GAP_CLKS+5 cycles from start strobe to fin_sup_clk when stable on first poll; +GAP_CLKS+2 per failed poll.
// Backpressure: none; start strobes arriving while busy (including the END cycles) are dropped.
module sd_clk_supply_seq #(
    parameter int GAP_CLKS = 3,
    parameter int POLL_MAX = 1000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         supply_sd_clk_strb,
    input  logic [7:0]   freq_sel,
    output logic [11:0]  rd_reg_index,
    input  logic [127:0] rd_reg_input,
    output logic         wr_reg_strb,
    output logic [11:0]  wr_reg_index,
    output logic [31:0]  wr_reg_output,
    output logic [2:0]   reg_attr,
    output logic         sd_clk_on_suc,
    output logic         sd_clk_sup_err,
    output logic         fin_sup_clk,
    output logic         sd_clk_sup_proc
);

    localparam logic [11:0] CLK_CTRL_IDX = 12'h02C;
    localparam logic [2:0]  WR_ATTR      = 3'h3;
    localparam logic [3:0]  GAP_LAST     = 4'(GAP_CLKS - 1);
    localparam logic [15:0] POLL_LIMIT   = 16'(POLL_MAX);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        WR_INT      = 4'd1,
        WR_INT_WT   = 4'd2,
        RD_STB      = 4'd3,
        RD_WT       = 4'd4,
        CHK         = 4'd5,
        WR_SDCLK    = 4'd6,
        WR_SDCLK_WT = 4'd7,
        END_OK      = 4'd8,
        WR_ABORT    = 4'd9,
        WR_ABORT_WT = 4'd10,
        END_ERR     = 4'd11
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  gap_cnt;
    logic [15:0] poll_cnt;
    logic [15:0] poll_inc;
    logic        stable_q;
    logic [7:0]  fsel_q;
    logic [7:0]  fsel_d;
    logic        start;
    logic        in_wait;
    logic        gap_done;

    // Only Internal Clock Stable is consumed from the wide read bus.
    logic unused_rd_bits;
    assign unused_rd_bits = ^{rd_reg_input[127:2], rd_reg_input[0]};

    assign start    = (state == IDLE) && supply_sd_clk_strb;
    assign in_wait  = (state == WR_INT_WT) || (state == RD_WT) ||
                      (state == WR_SDCLK_WT) || (state == WR_ABORT_WT);
    assign gap_done = (gap_cnt == GAP_LAST);
    assign poll_inc = poll_cnt + 16'd1;
    // Outputs are registered from next_state, so the write data must see the value being latched now.
    assign fsel_d   = start ? freq_sel : fsel_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:        next_state = start ? WR_INT : IDLE;
            WR_INT:      next_state = WR_INT_WT;
            WR_INT_WT:   next_state = gap_done ? RD_STB : WR_INT_WT;
            RD_STB:      next_state = RD_WT;
            RD_WT:       next_state = gap_done ? CHK : RD_WT;
            CHK: begin
                if (stable_q) begin
                    next_state = WR_SDCLK;
                end else if (poll_inc == POLL_LIMIT) begin
                    next_state = WR_ABORT;
                end else begin
                    next_state = RD_STB;
                end
            end
            WR_SDCLK:    next_state = WR_SDCLK_WT;
            WR_SDCLK_WT: next_state = gap_done ? END_OK : WR_SDCLK_WT;
            END_OK:      next_state = IDLE;
            WR_ABORT:    next_state = WR_ABORT_WT;
            WR_ABORT_WT: next_state = gap_done ? END_ERR : WR_ABORT_WT;
            END_ERR:     next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    // Sequencer datapath: gap timer, poll counter, latched stable bit and frequency select
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt  <= '0;
            poll_cnt <= '0;
            stable_q <= 1'b0;
            fsel_q   <= '0;
        end else begin
            if (in_wait && !gap_done) begin
                gap_cnt <= gap_cnt + 4'd1;
            end else begin
                gap_cnt <= '0;
            end

            if (start) begin
                fsel_q   <= freq_sel;
                poll_cnt <= '0;
            end else if ((state == CHK) && !stable_q) begin
                poll_cnt <= poll_inc;
            end

            if ((state == RD_WT) && gap_done) begin
                stable_q <= rd_reg_input[1];
            end
        end
    end

    logic        rd_act_d;
    logic        wr_strb_d;
    logic        wr_act_d;
    logic [31:0] wr_dat_d;
    logic        suc_d;
    logic        err_d;
    logic        fin_d;
    logic        proc_d;

    // Output decode of the state being entered
    always_comb begin
        rd_act_d  = 1'b0;
        wr_strb_d = 1'b0;
        wr_act_d  = 1'b0;
        wr_dat_d  = 32'h0;
        suc_d     = 1'b0;
        err_d     = 1'b0;
        fin_d     = 1'b0;
        proc_d    = (next_state != IDLE);
        case (next_state)
            WR_INT, WR_INT_WT: begin
                wr_strb_d = (next_state == WR_INT);
                wr_act_d  = 1'b1;
                wr_dat_d  = {16'h0, fsel_d, 8'h01};
            end
            RD_STB, RD_WT: begin
                rd_act_d = 1'b1;
            end
            WR_SDCLK, WR_SDCLK_WT: begin
                wr_strb_d = (next_state == WR_SDCLK);
                wr_act_d  = 1'b1;
                wr_dat_d  = {16'h0, fsel_d, 8'h05};
            end
            WR_ABORT, WR_ABORT_WT: begin
                wr_strb_d = (next_state == WR_ABORT);
                wr_act_d  = 1'b1;
                wr_dat_d  = 32'h0;
            end
            END_OK: begin
                fin_d = 1'b1;
                suc_d = 1'b1;
            end
            END_ERR: begin
                fin_d = 1'b1;
                err_d = 1'b1;
            end
            default: begin
                proc_d = (next_state != IDLE);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_reg_index    <= '0;
            wr_reg_strb     <= 1'b0;
            wr_reg_index    <= '0;
            wr_reg_output   <= '0;
            reg_attr        <= '0;
            sd_clk_on_suc   <= 1'b0;
            sd_clk_sup_err  <= 1'b0;
            fin_sup_clk     <= 1'b0;
            sd_clk_sup_proc <= 1'b0;
        end else begin
            rd_reg_index    <= rd_act_d ? CLK_CTRL_IDX : 12'h0;
            wr_reg_strb     <= wr_strb_d;
            wr_reg_index    <= wr_act_d ? CLK_CTRL_IDX : 12'h0;
            wr_reg_output   <= wr_dat_d;
            reg_attr        <= wr_act_d ? WR_ATTR : 3'h0;
            sd_clk_on_suc   <= suc_d;
            sd_clk_sup_err  <= err_d;
            fin_sup_clk     <= fin_d;
            sd_clk_sup_proc <= proc_d;
        end
    end

endmodule

// File: doc/sd_clk_supply_seq.md
# sd_clk_supply_seq

Implements the SD Host Controller SD Clock Supply Sequence (spec 3.2.1): programs the SDCLK frequency select and Internal Clock Enable in the Clock Control register (02Ch), polls Internal Clock Stable, then sets SD Clock Enable. It is the turn-on counterpart of the clock stop sequencer. It sits beside that sequencer on the Host Controller memory-map register port and is triggered by the card-init / frequency-switch controller.

## Interface
- GAP_CLKS, 3: wait cycles after every register read or write strobe; range 2..15.
- POLL_MAX, 1000: number of failed Internal Clock Stable checks before the sequence aborts; 16-bit poll counter.
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- supply_sd_clk_strb  in  1  one-cycle start strobe; ignored while busy.
- freq_sel  in  8  SDCLK Frequency Select value, latched on the accepted start strobe.
- rd_reg_index  out  12  register read address.
- rd_reg_input  in  128  read data; bit 1 = Internal Clock Stable when index is 02Ch.
- wr_reg_strb  out  1  one-cycle register write strobe.
- wr_reg_index  out  12  register write address.
- wr_reg_output  out  32  register write data.
- reg_attr  out  3  register attribute; 3'h3 on writes, 3'h0 otherwise.
- sd_clk_on_suc  out  1  strobe: SD clock enabled.
- sd_clk_sup_err  out  1  strobe: Internal Clock Stable never seen; sequence aborted.
- fin_sup_clk  out  1  strobe: sequence finished (success or error).
- sd_clk_sup_proc  out  1  level: sequence in progress.

## Operation
- All outputs are registered and valid in the cycle the FSM occupies the state that drives them.
- IDLE: all outputs 0. On supply_sd_clk_strb: latch freq_sel into fsel_q, clear poll_cnt -> WR_INT.
- WR_INT (1 cycle): wr_reg_strb=1, wr_reg_index=02Ch, wr_reg_output={16'h0, fsel_q, 8'h01} (Internal Clock Enable=1, SD Clock Enable=0), reg_attr=3'h3 -> WR_INT_WT.
- WR_INT_WT (GAP_CLKS cycles): index/data/attr held, strobe 0 -> RD_STB.
- RD_STB (1 cycle): rd_reg_index=02Ch, starts gap counter -> RD_WT.
- RD_WT (GAP_CLKS cycles): rd_reg_index held 02Ch; in final cycle stable_q <= rd_reg_input[1] -> CHK.
- CHK (1 cycle): stable_q=1 -> WR_SDCLK. Else poll_cnt+1; if new poll_cnt == POLL_MAX -> WR_ABORT, else -> RD_STB.
- WR_SDCLK (1 cycle): write 02Ch with {16'h0, fsel_q, 8'h05} (SD Clock Enable=1, Internal Clock Enable=1) -> WR_SDCLK_WT (GAP_CLKS cycles) -> END_OK.
- END_OK (1 cycle): fin_sup_clk=1, sd_clk_on_suc=1 -> IDLE.
- WR_ABORT (1 cycle): write 02Ch with 32'h0 (internal clock disabled) -> WR_ABORT_WT (GAP_CLKS cycles) -> END_ERR.
- END_ERR (1 cycle): fin_sup_clk=1, sd_clk_sup_err=1 -> IDLE.
- sd_clk_sup_proc=1 in every state except IDLE.
- rd_reg_index=0 outside RD_STB/RD_WT; wr_reg_index, wr_reg_output, reg_attr = 0 outside write/write-wait states.
- Illegal state encoding: recover to IDLE with all outputs 0.
- freq_sel=0 (base clock) is legal and written unchanged.

## Timing
- Reset: state=IDLE; every output 0; poll_cnt=0, stable_q=0, fsel_q=0. Reset mid-sequence aborts immediately, no further writes, no fin strobe.
- Strobe sampled at edge E0 = cycle 0. Stable on first poll, GAP_CLKS=3: wr_reg_strb cycles 1 and 10; read window cycles 5-8; CHK cycle 9; fin_sup_clk + sd_clk_on_suc cycle 14.
- Each failed poll adds GAP_CLKS+2 cycles.
- Abort path: after the POLL_MAX-th failed CHK, abort write next cycle, fin_sup_clk + sd_clk_sup_err GAP_CLKS+1 cycles later.
- Strobe arriving in any non-IDLE state, including END_*, is dropped. Strobe in the IDLE cycle after END_* is accepted.
- sd_clk_on_suc and sd_clk_sup_err are never high together; each is coincident with fin_sup_clk.

## Test plan
- Stable=1 immediately, freq_sel=8'h80: writes 32'h00008001 (cycle 1) then 32'h00008005 (cycle 10); suc+fin at cycle 14; proc high cycles 1-14.
- Stable=0 for 3 polls then 1, freq_sel=8'h02: 4 read windows on 02Ch; second write 32'h00000205; fin at cycle 29.
- Stable never 1, POLL_MAX=4: exactly 4 reads, write 32'h0, err+fin strobe, suc never asserted.
- Second start strobe during RD_WT and during END_OK: ignored, exactly one sequence executed; strobe one cycle after END_OK starts a new sequence.
- Reset asserted in WR_SDCLK_WT: next cycle all outputs 0, state IDLE; new strobe runs a full sequence correctly.
- freq_sel changes after the start strobe: all writes use the latched value.
